// File: rtl/spi_sram_pkg.sv
// Shared constants, state encoding and frame builder for the SPI SRAM bridge.
package spi_sram_pkg;

  localparam logic [7:0] SRAM_CMD_READ  = 8'h03;
  localparam logic [7:0] SRAM_CMD_WRITE = 8'h02;

  localparam int unsigned FRAME_BITS = 48;
  localparam int unsigned DATA_BITS  = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT,
    StHold  = ST_HOLD
  } state_e;

  // Word address becomes a 24-bit byte address: {7'b0, addr, 1'b0}.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic           we,
                                                        input logic [15:0]    addr,
                                                        input logic [15:0]    wdata);
    return {(we ? SRAM_CMD_WRITE : SRAM_CMD_READ), 7'b0, addr, 1'b0, wdata};
  endfunction

endpackage

// File: rtl/spi_sram_bridge_if.sv
// Memory-request and SPI pin bundle for the SPI SRAM bridge.
interface spi_sram_bridge_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ready;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;

  modport slave (
    input  req, we, addr, wdata, spi_miso,
    output rdata, ready, spi_sck, spi_cs_n, spi_mosi
  );

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready
  );

  modport mem (
    input  spi_sck, spi_cs_n, spi_mosi,
    output spi_miso
  );
endinterface

// File: rtl/spi_clk_div.sv
// SCK phase divider: CLK_DIV clks per half-period, one-clk registered rise/fall ticks.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam int unsigned CntW = $clog2(CLK_DIV) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_phase, w_phase_d;
  logic            r_rise, w_rise_d;
  logic            r_fall, w_fall_d;

  always_comb begin
    w_cnt_d   = r_cnt;
    w_phase_d = r_phase;
    w_rise_d  = 1'b0;
    w_fall_d  = 1'b0;
    if (!i_en) begin
      w_cnt_d   = '0;
      w_phase_d = 1'b0;
    end else if (r_cnt == CntMax) begin
      w_cnt_d   = '0;
      w_phase_d = ~r_phase;
      w_rise_d  = ~r_phase;
      w_fall_d  = r_phase;
    end else begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_d;
      r_phase <= w_phase_d;
      r_rise  <= w_rise_d;
      r_fall  <= w_fall_d;
    end
  end

  assign o_rise_tick = r_rise;
  assign o_fall_tick = r_fall;

endmodule

// File: rtl/spi_sram_bridge.sv
// Word-request to SPI frame bridge for a 23LC1024-class SRAM (mode 0, sequential).
module spi_sram_bridge
  import spi_sram_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input logic              i_clk,
  input logic              i_rst_n,
  spi_sram_bridge_if.slave io_bus
);

  state_e                  r_state, w_state_d;
  logic [FRAME_BITS-1:0]   r_tx, w_tx_d;
  logic [DATA_BITS-1:0]    r_rx, w_rx_d;
  logic [DATA_BITS-1:0]    r_rdata, w_rdata_d;
  logic [5:0]              r_bit_cnt, w_bit_cnt_d;
  logic                    r_we, w_we_d;
  logic                    r_sck, w_sck_d;
  logic                    r_cs_n, w_cs_n_d;
  logic                    r_ready, w_ready_d;

  logic                    w_rise_tick;
  logic                    w_fall_tick;
  logic                    w_div_en;
  logic [FRAME_BITS-1:0]   w_frame;

  assign w_div_en = (r_state == StShift);
  assign w_frame  = build_frame(io_bus.we, io_bus.addr, io_bus.wdata);

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (w_div_en),
    .o_rise_tick (w_rise_tick),
    .o_fall_tick (w_fall_tick)
  );

  always_comb begin
    w_state_d   = r_state;
    w_tx_d      = r_tx;
    w_rx_d      = r_rx;
    w_rdata_d   = r_rdata;
    w_bit_cnt_d = r_bit_cnt;
    w_we_d      = r_we;
    w_sck_d     = r_sck;
    w_cs_n_d    = r_cs_n;
    w_ready_d   = r_ready;
    unique case (r_state)
      StIdle: begin
        if (io_bus.req) begin
          w_tx_d      = w_frame;
          w_we_d      = io_bus.we;
          w_bit_cnt_d = '0;
          w_cs_n_d    = 1'b0;
          w_ready_d   = 1'b0;
          w_state_d   = StShift;
        end
      end
      StShift: begin
        if (w_rise_tick) begin
          w_sck_d = 1'b1;
          w_rx_d  = {r_rx[DATA_BITS-2:0], io_bus.spi_miso};
        end
        if (w_fall_tick) begin
          w_sck_d = 1'b0;
          w_tx_d  = {r_tx[FRAME_BITS-2:0], 1'b0};
          if (r_bit_cnt == 6'(FRAME_BITS - 1)) begin
            w_state_d = StHold;
          end else begin
            w_bit_cnt_d = r_bit_cnt + 6'd1;
          end
        end
      end
      StHold: begin
        w_cs_n_d  = 1'b1;
        w_ready_d = 1'b1;
        w_state_d = StIdle;
        if (!r_we) begin
          w_rdata_d = r_rx;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Reset wins even mid-frame; the partial receive word never reaches rdata.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rdata   <= '0;
      r_bit_cnt <= '0;
      r_we      <= 1'b0;
      r_sck     <= 1'b0;
      r_cs_n    <= 1'b1;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state_d;
      r_tx      <= w_tx_d;
      r_rx      <= w_rx_d;
      r_rdata   <= w_rdata_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_we      <= w_we_d;
      r_sck     <= w_sck_d;
      r_cs_n    <= w_cs_n_d;
      r_ready   <= w_ready_d;
    end
  end

  // MOSI is the registered MSB of the TX shifter, so it changes only on falling SCK.
  assign io_bus.spi_mosi = r_tx[FRAME_BITS-1];
  assign io_bus.spi_sck  = r_sck;
  assign io_bus.spi_cs_n = r_cs_n;
  assign io_bus.ready    = r_ready;
  assign io_bus.rdata    = r_rdata;

endmodule

// File: tb/tb_spi_sram_bridge.sv
// Directed bench for spi_sram_bridge: CLK_DIV=2 and CLK_DIV=3 instances with SRAM models.
module tb_spi_sram_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_sram_bridge_if bif0 ();
  spi_sram_bridge_if bif1 ();

  spi_sram_bridge #(.CLK_DIV(2)) u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bif0));
  spi_sram_bridge #(.CLK_DIV(3)) u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(bif1));

  int n_cmp = 0;
  int n_err = 0;

  // SRAM models: capture MOSI on SCK rise, serve word in the data phase.
  int          rises0 = 0, frames0 = 0, rises1 = 0, frames1 = 0;
  logic [47:0] cap0 = '0, cap1 = '0;
  logic [15:0] word0 = '0, word1 = '0;

  always @(negedge bif0.spi_cs_n or posedge bif0.spi_sck) begin
    if (bif0.spi_sck) begin
      rises0 <= rises0 + 1;
      cap0   <= {cap0[46:0], bif0.spi_mosi};
    end else begin
      rises0  <= 0;
      frames0 <= frames0 + 1;
    end
  end

  always @(negedge bif1.spi_cs_n or posedge bif1.spi_sck) begin
    if (bif1.spi_sck) begin
      rises1 <= rises1 + 1;
      cap1   <= {cap1[46:0], bif1.spi_mosi};
    end else begin
      rises1  <= 0;
      frames1 <= frames1 + 1;
    end
  end

  assign bif0.spi_miso = (rises0 >= 32 && rises0 < 48) ? word0[4'(47 - rises0)] : 1'b0;
  assign bif1.spi_miso = (rises1 >= 32 && rises1 < 48) ? word1[4'(47 - rises1)] : 1'b0;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic req, input logic we,
                       input logic [15:0] addr, input logic [15:0] wdata);
    if (sel == 0) begin
      bif0.req = req; bif0.we = we; bif0.addr = addr; bif0.wdata = wdata;
    end else begin
      bif1.req = req; bif1.we = we; bif1.addr = addr; bif1.wdata = wdata;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? bif0.ready : bif1.ready;
  endfunction

  function automatic logic get_sck(input int sel);
    return (sel == 0) ? bif0.spi_sck : bif1.spi_sck;
  endfunction

  function automatic logic get_cs_n(input int sel);
    return (sel == 0) ? bif0.spi_cs_n : bif1.spi_cs_n;
  endfunction

  // Issue one request, wait (bounded) for ready, and measure SCK phase lengths.
  task automatic run_txn(input int sel, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input bit pulse,
                         output int lat, output int hi_runs, output int bad_runs,
                         output logic acc_cs_n, output logic acc_ready);
    int   d;
    int   run;
    logic prev;
    logic s;
    bit   first_low;
    d = (sel == 0) ? 2 : 3;
    drive(sel, 1'b1, we, addr, wdata);
    tick();
    acc_cs_n  = get_cs_n(sel);
    acc_ready = get_ready(sel);
    drive(sel, pulse, ~we, 16'h0000, 16'h0000);
    lat = 0; hi_runs = 0; bad_runs = 0;
    prev = get_sck(sel); run = 1; first_low = 1'b1;
    while (lat < 2000) begin
      tick();
      lat++;
      s = get_sck(sel);
      if (s == prev) begin
        run++;
      end else begin
        if (prev) begin
          hi_runs++;
          if (run != d) bad_runs++;
        end else begin
          if (!first_low && run != d) bad_runs++;
          first_low = 1'b0;
        end
        prev = s;
        run  = 1;
      end
      if (get_ready(sel)) begin
        drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000);
        break;
      end
    end
  endtask

  int   lat, hi, bad, f_before;
  logic acs, ardy;

  initial begin
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_ready", 48'(bif0.ready), 48'd1);
    check("rst_cs_n", 48'(bif0.spi_cs_n), 48'd1);
    check("rst_sck", 48'(bif0.spi_sck), 48'd0);
    check("rst_rdata", 48'(bif0.rdata), 48'h0000);
    check("rst_no_sck", 48'(rises0), 48'd0);
    check("rst_ready_d3", 48'(bif1.ready), 48'd1);
    rst_n = 1'b1;
    tick();

    // Abandon a read at the 20th SCK rise.
    word0 = 16'h1357;
    drive(0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    tick();
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 500 && rises0 < 20; i++) tick();
    check("mid_reached20", 48'(rises0), 48'd20);
    rst_n = 1'b0;
    tick();
    check("mid_cs_n", 48'(bif0.spi_cs_n), 48'd1);
    check("mid_sck", 48'(bif0.spi_sck), 48'd0);
    check("mid_ready", 48'(bif0.ready), 48'd1);
    check("mid_rdata", 48'(bif0.rdata), 48'h0000);
    rst_n = 1'b1;
    repeat (10) tick();
    check("mid_no_more_sck", 48'(rises0), 48'd20);

    // Read 0x0010, SRAM returns A55A.
    word0 = 16'hA55A;
    run_txn(0, 1'b0, 16'h0010, 16'h0000, 1'b0, lat, hi, bad, acs, ardy);
    check("rd_accept_cs_n", 48'(acs), 48'd0);
    check("rd_accept_ready", 48'(ardy), 48'd0);
    check("rd_latency", 48'(lat), 48'd194);
    check("rd_mosi_hdr", 48'(cap0[47:16]), 48'h03000020);
    check("rd_rdata", 48'(bif0.rdata), 48'hA55A);
    check("rd_sck_rises", 48'(rises0), 48'd48);
    check("rd_sck_phases", 48'(bad), 48'd0);

    // Write 0x1234 <- BEEF; rdata must keep the last read.
    word0 = 16'h0F0F;
    tick();
    run_txn(0, 1'b1, 16'h1234, 16'hBEEF, 1'b0, lat, hi, bad, acs, ardy);
    check("wr_latency", 48'(lat), 48'd194);
    check("wr_mosi", cap0, 48'h02002468BEEF);
    check("wr_sck_rises", 48'(rises0), 48'd48);
    check("wr_rdata_kept", 48'(bif0.rdata), 48'hA55A);

    // Top address with req hammered while busy: one frame only.
    word0 = 16'hC3C3;
    tick();
    f_before = frames0;
    run_txn(0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, lat, hi, bad, acs, ardy);
    repeat (3) tick();
    check("bnd_one_frame", 48'(frames0 - f_before), 48'd1);
    check("bnd_mosi_hdr", 48'(cap0[47:16]), 48'h0301FFFE);
    check("bnd_rdata", 48'(bif0.rdata), 48'hC3C3);
    check("bnd_idle_cs_n", 48'(bif0.spi_cs_n), 48'd1);

    // CLK_DIV=3 read.
    word1 = 16'h6C39;
    run_txn(1, 1'b0, 16'h0ABC, 16'h0000, 1'b0, lat, hi, bad, acs, ardy);
    check("d3_latency", 48'(lat), 48'd290);
    check("d3_high_phases", 48'(hi), 48'd48);
    check("d3_phase_len", 48'(bad), 48'd0);
    check("d3_mosi_hdr", 48'(cap1[47:16]), 48'h03001578);
    check("d3_rdata", 48'(bif1.rdata), 48'h6C39);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
